// File: rtl/alu8_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : alu8_accumulator
//  Description : 8-bit accumulator ALU; single-cycle logic/arith ops and an
//                iterative 8-cycle shift-add multiply.
//  Revision    : 1.0  initial release
// ============================================================================
module alu8_accumulator #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] inData,
    input  logic [2:0] inOp,
    input  logic       inValid,
    output logic       busy,
    output logic [7:0] out,
    output logic       outValid,
    output logic       zero,
    output logic       carry
);

    localparam logic [2:0] c_OP_LOAD = 3'd0;
    localparam logic [2:0] c_OP_AND  = 3'd1;
    localparam logic [2:0] c_OP_OR   = 3'd2;
    localparam logic [2:0] c_OP_XOR  = 3'd3;
    localparam logic [2:0] c_OP_ADD  = 3'd4;
    localparam logic [2:0] c_OP_SUB  = 3'd5;
    localparam logic [2:0] c_OP_NOT  = 3'd6;
    localparam logic [2:0] c_OP_MUL  = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        valid_q, valid_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [8:0]  w_sum;
    logic [8:0]  w_diff;
    logic [15:0] w_partial;

    assign w_sum     = {1'b0, acc_q} + {1'b0, inData};
    // Bit 8 of the 9-bit difference is the borrow (acc < inData).
    assign w_diff    = {1'b0, acc_q} - {1'b0, inData};
    assign w_partial = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    valid_d = 1'b1;
                    carry_d = 1'b0;
                    case (inOp)
                        c_OP_LOAD: acc_d = inData;
                        c_OP_AND:  acc_d = acc_q & inData;
                        c_OP_OR:   acc_d = acc_q | inData;
                        c_OP_XOR:  acc_d = acc_q ^ inData;
                        c_OP_ADD: begin
                            acc_d   = w_sum[7:0];
                            carry_d = w_sum[8];
                        end
                        c_OP_SUB: begin
                            acc_d   = w_diff[7:0];
                            carry_d = w_diff[8];
                        end
                        c_OP_NOT:  acc_d = ~acc_q;
                        default: begin
                            // Multiply: latch operands, results stay untouched.
                            valid_d  = 1'b0;
                            carry_d  = carry_q;
                            state_d  = MUL;
                            prod_d   = 16'h0000;
                            mcand_d  = {8'h00, acc_q};
                            mplier_d = inData;
                            cnt_d    = 3'd0;
                        end
                    endcase
                    zero_d = (acc_d == 8'h00);
                end
            end
            MUL: begin
                prod_d   = w_partial;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[7:1]};
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    acc_d   = w_partial[7:0];
                    carry_d = |w_partial[15:8];
                    zero_d  = (w_partial[7:0] == 8'h00);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= RESET_VALUE;
            carry_q  <= 1'b0;
            zero_q   <= (RESET_VALUE == 8'h00);
            valid_q  <= 1'b0;
            prod_q   <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            cnt_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy     = (state_q == MUL);
    assign out      = acc_q;
    assign outValid = valid_q;
    assign zero     = zero_q;
    assign carry    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_alu8_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu8_accumulator
//  Description : Scoreboard bench for alu8_accumulator with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu8_accumulator;

    localparam logic [2:0] c_LOAD = 3'd0;
    localparam logic [2:0] c_AND  = 3'd1;
    localparam logic [2:0] c_OR   = 3'd2;
    localparam logic [2:0] c_XOR  = 3'd3;
    localparam logic [2:0] c_ADD  = 3'd4;
    localparam logic [2:0] c_SUB  = 3'd5;
    localparam logic [2:0] c_NOT  = 3'd6;
    localparam logic [2:0] c_MUL  = 3'd7;

    logic       clk;
    logic       reset;
    logic [7:0] inData;
    logic [2:0] inOp;
    logic       inValid;
    logic       busy;
    logic [7:0] out;
    logic       outValid;
    logic       zero;
    logic       carry;

    typedef struct packed {
        logic [7:0] o;
        logic       c;
        logic       z;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    alu8_accumulator #(.RESET_VALUE(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .inData   (inData),
        .inOp     (inOp),
        .inValid  (inValid),
        .busy     (busy),
        .out      (out),
        .outValid (outValid),
        .zero     (zero),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] o, input logic c, input logic z);
        exp_t e;
        e.o = o;
        e.c = c;
        e.z = z;
        q.push_back(e);
    endtask

    // Drive one request for a single cycle; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] op, input logic [7:0] d);
        inOp    = op;
        inData  = d;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic mul_op(input logic [7:0] d, input logic [7:0] eo, input logic ec,
                          input logic ez, input bit inject);
        logic [7:0] prev;
        prev = out;
        push(eo, ec, ez);
        issue(c_MUL, d);
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy", {15'd0, busy}, 16'd1);
            chk("mul_no_valid", {15'd0, outValid}, 16'd0);
            chk("mul_out_hold", {8'd0, out}, {8'd0, prev});
            if (inject && i == 2) begin
                inOp    = c_LOAD;
                inData  = 8'h77;
                inValid = 1'b1;
            end
            @(negedge clk);
            inValid = 1'b0;
        end
        chk("mul_busy_done", {15'd0, busy}, 16'd0);
        chk("mul_valid_pulse", {15'd0, outValid}, 16'd1);
    endtask

    // Monitor: every outValid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (outValid) begin
            if (q.size() == 0) begin
                chk("spurious_outValid", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_out", {8'd0, out}, {8'd0, e.o});
                chk("sb_carry", {15'd0, carry}, {15'd0, e.c});
                chk("sb_zero", {15'd0, zero}, {15'd0, e.z});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        inValid = 1'b1;
        inOp    = c_LOAD;
        inData  = 8'h55;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        inValid = 1'b0;
        chk("rst_out", {8'd0, out}, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        chk("rst_carry", {15'd0, carry}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, outValid}, 16'd0);

        push(8'hC3, 1'b0, 1'b0); issue(c_LOAD, 8'hC3);
        chk("load_pulse", {15'd0, outValid}, 16'd1);
        push(8'hC0, 1'b0, 1'b0); issue(c_AND, 8'hF0);
        chk("and_pulse", {15'd0, outValid}, 16'd1);
        @(negedge clk);
        chk("pulse_end", {15'd0, outValid}, 16'd0);

        push(8'hFF, 1'b0, 1'b0); issue(c_LOAD, 8'hFF);
        push(8'h00, 1'b1, 1'b1); issue(c_ADD, 8'h01);
        push(8'h05, 1'b0, 1'b0); issue(c_LOAD, 8'h05);
        push(8'hFF, 1'b1, 1'b0); issue(c_SUB, 8'h06);
        push(8'h00, 1'b0, 1'b1); issue(c_NOT, 8'h5A);
        push(8'h3C, 1'b0, 1'b0); issue(c_LOAD, 8'h3C);
        push(8'h3F, 1'b0, 1'b0); issue(c_OR, 8'h0F);
        push(8'hC0, 1'b0, 1'b0); issue(c_XOR, 8'hFF);
        push(8'hC1, 1'b0, 1'b0); issue(c_ADD, 8'h01);
        push(8'hB1, 1'b0, 1'b0); issue(c_SUB, 8'h10);
        @(negedge clk);

        push(8'h12, 1'b0, 1'b0); issue(c_LOAD, 8'h12);
        mul_op(8'h0A, 8'hB4, 1'b0, 1'b0, 1'b0);
        mul_op(8'h10, 8'h40, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("after_drop_out", {8'd0, out}, 16'h0040);

        // Reset lands on the 4th multiply cycle: no commit, no pulse.
        push(8'h33, 1'b0, 1'b0); issue(c_LOAD, 8'h33);
        issue(c_MUL, 8'h02);
        for (int i = 0; i < 3; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", {8'd0, out}, 16'h0000);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_valid", {15'd0, outValid}, 16'd0);
        chk("abort_carry", {15'd0, carry}, 16'd0);
        chk("abort_zero", {15'd0, zero}, 16'd1);
        push(8'h01, 1'b0, 1'b0); issue(c_LOAD, 8'h01);
        chk("post_rst_pulse", {15'd0, outValid}, 16'd1);
        chk("post_rst_out", {8'd0, out}, 16'h0001);

        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("sb_drained", q.size()[15:0], 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu8_accumulator.md
ALU8_ACCUMULATOR -- requirements
Module: alu8_accumulator

Interface
REQ-001 Parameter: RESET_VALUE, 8'h00, value loaded into the accumulator on reset.
REQ-002 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: inData  input  8  operand B; operand A is the accumulator.
REQ-006 Port: inOp  input  3  opcode: 0 LOAD, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 NOT, 7 MUL.
REQ-007 Port: inValid  input  1  request strobe; sampled with inData and inOp.
REQ-008 Port: busy  output  1  high while a MUL is in progress; requests are not accepted.
REQ-009 Port: out  output  8  accumulator contents.
REQ-010 Port: outValid  output  1  one-cycle pulse when a new result has been committed to out.
REQ-011 Port: zero  output  1  high when the committed out equals 8'h00.
REQ-012 Port: carry  output  1  carry or borrow flag of the last committed operation.

Function
REQ-013 A request SHALL be accepted on a rising edge where inValid=1, busy=0 and reset=0.
REQ-014 A request presented while busy=1 SHALL be dropped without any effect; there is no queueing.
REQ-015 LOAD, AND, OR, XOR, ADD, SUB and NOT SHALL commit at the accepting edge; outValid SHALL be high for exactly the following cycle.
REQ-016 The operations SHALL compute: LOAD out=inData; AND out=acc&inData; OR out=acc|inData; XOR out=acc^inData; NOT out=~acc, with inData ignored.
REQ-017 ADD SHALL compute out={acc+inData}[7:0], with carry equal to bit 8 of the 9-bit sum.
REQ-018 SUB SHALL compute out=(acc-inData) mod 256, with carry=1 exactly when acc<inData (borrow).
REQ-019 LOAD, AND, OR, XOR and NOT SHALL clear carry.
REQ-020 MUL SHALL be an iterative shift-add of acc times inData, one multiplier bit per cycle; the operands SHALL be latched at acceptance.
REQ-021 MUL result SHALL be the low byte of the 16-bit product, with carry=1 exactly when the high byte is nonzero.
REQ-022 The FSM SHALL have the states IDLE and MUL.
REQ-023 IDLE SHALL transition to MUL on acceptance of opcode 7.
REQ-024 MUL SHALL run 8 cycles, then commit and return to IDLE.
REQ-025 For MUL accepted at edge N: busy SHALL be high from after edge N until after edge N+8; the commit SHALL occur at edge N+8; outValid SHALL be high in the cycle after edge N+8.
REQ-026 A new request SHALL be acceptable at edge N+9 at the earliest.
REQ-027 out, zero and carry SHALL hold their values while busy=1.
REQ-028 out, zero and carry SHALL change only on a commit or on reset.
REQ-029 zero SHALL be updated on every commit to reflect the new out.
REQ-030 Back-to-back single-cycle requests SHALL be accepted on consecutive edges, each producing its own outValid pulse, so outValid may stay high across consecutive cycles.
REQ-031 ADD wrap-around SHALL be modulo 256: 8'hFF+8'h01 gives out=8'h00, carry=1, zero=1.

Reset
REQ-032 While reset=1 at an edge, the block SHALL set out=RESET_VALUE, carry=0, zero=(RESET_VALUE==0), outValid=0, busy=0, and state=IDLE.
REQ-033 Reset SHALL take priority over a simultaneous inValid; the request SHALL be discarded.
REQ-034 Reset during MUL SHALL abort the operation with no commit and no outValid pulse.

Verification
REQ-035 Bench SHALL cover: LOAD 8'hC3, then AND 8'hF0 -> out=8'hC0, carry=0, zero=0, with one outValid pulse per operation.
REQ-036 Bench SHALL cover: LOAD 8'hFF, then ADD 8'h01 -> out=8'h00, carry=1, zero=1.
REQ-037 Bench SHALL cover: LOAD 8'h05, then SUB 8'h06 -> out=8'hFF, carry=1; then NOT -> out=8'h00, carry=0, zero=1.
REQ-038 Bench SHALL cover: LOAD 8'h12, then MUL 8'h0A -> busy high 8 cycles, out=8'hB4, carry=0, outValid in the cycle after edge N+8; a second MUL 8'h10 -> out=8'h40, carry=1.
REQ-039 Bench SHALL cover: during a MUL, inValid with LOAD 8'h77 -> request ignored, and the MUL result is unaffected.
REQ-040 Bench SHALL cover: reset asserted at the 4th MUL cycle -> out=RESET_VALUE, busy=0, no outValid; LOAD 8'h01 is accepted the edge after reset is released.
